// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command receiver/transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

  // 50 MHz core clock at 19200 baud.
  localparam int BAUD_DIV_DEFAULT = 2604;

  // Bytes per assembled command.
  localparam int CMD_BYTES = 3;

  // Command assembler: which command byte the next received byte fills.
  typedef enum logic [1:0] {
    WAIT_B1 = 2'd0,
    WAIT_B2 = 2'd1,
    WAIT_B3 = 2'd2
  } asm_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Assembler successor state after one completed byte.
  function automatic asm_state_t asm_next(input asm_state_t s);
    case (s)
      WAIT_B1: asm_next = WAIT_B2;
      WAIT_B2: asm_next = WAIT_B3;
      default: asm_next = WAIT_B1;
    endcase
  endfunction

endpackage

// File: rtl/uart.sv
// 8N1 serialiser/deserialiser with independent full-duplex RX and TX paths.
// Latency: RX byte flagged at stop-bit mid sample; TX line drives start bit the clock after trmt.
// Backpressure: none; trmt while busy is dropped, rdy is set-dominant over clr_rdy.
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- receive
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  rx_state_t       rx_state;
  rx_state_t       rx_nxt;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_go;
  logic            rx_half;
  logic            rx_tick;

  // Two-flop synchroniser plus a history flop for falling-edge detection; all idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_nxt;
  end

  // RX next state: a start bit that reads high at mid-bit was a glitch.
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_go) rx_nxt = RX_START;
      RX_START: if (rx_half) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // RX strobes: start edge, start-bit midpoint, and mid-bit sample points thereafter.
  always_comb begin
    rx_go   = 1'b0;
    rx_half = 1'b0;
    rx_tick = 1'b0;
    case (rx_state)
      RX_IDLE:          rx_go   = rx_prev & ~rx_sync;
      RX_START:         rx_half = (rx_cnt == HALF_LAST);
      RX_DATA, RX_STOP: rx_tick = (rx_cnt == BIT_LAST);
      default:          ;
    endcase
  end

  // RX datapath: after the half-bit alignment, samples land one full bit apart at mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      if (rx_go || rx_half || rx_tick) rx_cnt <= '0;
      else if (rx_state != RX_IDLE)     rx_cnt <= rx_cnt + 1'b1;

      if (rx_go) rx_bit <= '0;

      if (rx_tick && rx_state == RX_DATA) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end

      // A low stop bit is a framing error: the byte is silently dropped.
      if (rx_tick && rx_state == RX_STOP && rx_sync) begin
        rdy     <= 1'b1;
        rx_data <= rx_shift;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- transmit
  tx_state_t       tx_state;
  tx_state_t       tx_nxt;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_load;
  logic            tx_end;

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_nxt;
  end

  // TX next state: start, eight data bits, stop.
  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_nxt = TX_START;
      TX_START: if (tx_end) tx_nxt = TX_DATA;
      TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_nxt = TX_STOP;
      TX_STOP:  if (tx_end) tx_nxt = TX_IDLE;
      default:  tx_nxt = TX_IDLE;
    endcase
  end

  // TX strobes: accept only while idle; bit boundary when the divider wraps.
  always_comb begin
    tx_load = 1'b0;
    tx_end  = 1'b0;
    case (tx_state)
      TX_IDLE: tx_load = trmt;
      default: tx_end  = (tx_cnt == BIT_LAST);
    endcase
  end

  // TX datapath: TX is registered so each bit holds exactly BAUD_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= tx_data;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      TX       <= 1'b0;
      tx_done  <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (!tx_end) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            TX       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          TX_DATA: begin
            if (tx_bit == 3'd7) begin
              TX <= 1'b1;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end
          TX_STOP: tx_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_comm.sv
// UART command front end: assembles three received bytes into a 24-bit command.
// Latency: cmd_rdy rises the clock after the third byte is flagged by the UART.
// Backpressure: none; a new first byte overwrites cmd[23:16] and drops cmd_rdy.
module uart_comm
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_cmd_rdy,
  input  logic                   trmt,
  input  logic [7:0]             tx_data,
  input  logic                   RX,
  output logic                   cmd_rdy,
  output logic [CMD_BYTES*8-1:0] cmd,
  output logic                   tx_done,
  output logic                   TX
);

  logic [7:0] rx_byte;
  logic       byte_rdy;
  asm_state_t state;
  asm_state_t state_nxt;
  logic       ld_b1;
  logic       ld_b2;
  logic       ld_b3;

  // rdy is acknowledged immediately, so byte_rdy is a one-clock pulse per byte.
  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .trmt    (trmt),
    .TX      (TX),
    .tx_done (tx_done),
    .RX      (RX),
    .rx_data (rx_byte),
    .rdy     (byte_rdy),
    .clr_rdy (byte_rdy)
  );

  // Assembler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_B1;
    else     state <= state_nxt;
  end

  // Next state: a completing byte advances from the current slot even if the
  // consumer is acknowledging; otherwise the acknowledge realigns to byte 1.
  always_comb begin
    state_nxt = state;
    if (byte_rdy)         state_nxt = asm_next(state);
    else if (clr_cmd_rdy) state_nxt = WAIT_B1;
  end

  // Output decode: which command slot the arriving byte loads.
  always_comb begin
    ld_b1 = byte_rdy && (state == WAIT_B1);
    ld_b2 = byte_rdy && (state == WAIT_B2);
    ld_b3 = byte_rdy && (state == WAIT_B3);
  end

  // Command register and ready flag; completing the third byte beats the acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (ld_b1) cmd[23:16] <= rx_byte;
      if (ld_b2) cmd[15:8]  <= rx_byte;
      if (ld_b3) cmd[7:0]   <= rx_byte;

      if (ld_b3)                        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || byte_rdy) cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_comm.sv
module tb_uart_comm;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        RX = 1'b1;
  logic        cmd_rdy;
  logic [23:0] cmd;
  logic        tx_done;
  logic        TX;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rise_cnt = 0;
  logic cmd_rdy_q = 1'b0;

  always #5 clk = ~clk;

  uart_comm #(
    .BAUD_DIV(BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_cmd_rdy (clr_cmd_rdy),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .RX          (RX),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .tx_done     (tx_done),
    .TX          (TX)
  );

  // Count cmd_rdy rising edges, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && cmd_rdy_q !== 1'b1) rise_cnt++;
    cmd_rdy_q = cmd_rdy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bench-side UART sender: start, 8 data LSB first, stop, then a short idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic [9:0] line;   // line[i] = i-th bit time on TX
  } tx_vec_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          clr_hold;
    logic [23:0] exp;
  } cmd_vec_t;

  tx_vec_t  txv [3];
  cmd_vec_t cv  [4];

  initial begin
    int  r0;
    logic seen;

    txv[0] = '{dat: 8'hA5, line: 10'b1101001010};
    txv[1] = '{dat: 8'h3C, line: 10'b1001111000};
    txv[2] = '{dat: 8'h01, line: 10'b1000000010};

    cv[0] = '{b0: 8'h02, b1: 8'h1A, b2: 8'hBC, clr_hold: 1,  exp: 24'h021ABC};
    cv[1] = '{b0: 8'h09, b1: 8'h36, b2: 8'hCA, clr_hold: 30, exp: 24'h0936CA};
    cv[2] = '{b0: 8'hFF, b1: 8'h00, b2: 8'h81, clr_hold: 3,  exp: 24'hFF0081};
    cv[3] = '{b0: 8'h5A, b1: 8'hA5, b2: 8'h3C, clr_hold: 2,  exp: 24'h5AA53C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_TX", TX, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_cmd", cmd, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Transmit frames; a second trmt in mid-frame must be ignored.
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      tx_data = txv[v].dat;
      trmt = 1'b1;
      @(negedge clk);
      trmt = 1'b0;
      repeat (7) @(negedge clk);
      check($sformatf("tx%0d_done_cleared", v), tx_done, 0);
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin
          for (int j = 0; j < BAUD; j++) begin
            @(negedge clk);
            if (i == 4 && j == 0) begin
              trmt = 1'b1;
              tx_data = ~txv[v].dat;
            end else begin
              trmt = 1'b0;
            end
          end
        end
        check($sformatf("tx%0d_bit%0d", v, i), TX, txv[v].line[i]);
      end
      repeat (8) @(negedge clk);
      check($sformatf("tx%0d_done_early", v), tx_done, 0);
      @(negedge clk);
      check($sformatf("tx%0d_done", v), tx_done, 1);
      check($sformatf("tx%0d_idle", v), TX, 1);
    end

    // Command assembly from the table
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      repeat (cv[v].clr_hold) @(negedge clk);
      check($sformatf("cmd%0d_clr_low", v), cmd_rdy, 0);
      clr_cmd_rdy = 1'b0;
      r0 = rise_cnt;
      send_frame(cv[v].b0, 1'b1);
      send_frame(cv[v].b1, 1'b1);
      check($sformatf("cmd%0d_partial", v), cmd_rdy, 0);
      send_frame(cv[v].b2, 1'b1);
      check($sformatf("cmd%0d_rdy", v), cmd_rdy, 1);
      check($sformatf("cmd%0d_val", v), cmd, cv[v].exp);
      check($sformatf("cmd%0d_rises", v), rise_cnt - r0, 1);
      repeat (20) @(negedge clk);
      check($sformatf("cmd%0d_hold", v), {cmd_rdy, cmd}, {1'b1, cv[v].exp});
    end

    // Two stale bytes then an acknowledge: the next three bytes form the command.
    pulse_clr();
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b1);
    pulse_clr();
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    send_frame(8'hCC, 1'b1);
    check("stale_rdy", cmd_rdy, 1);
    check("stale_cmd", cmd, 24'hAABBCC);

    // Start glitch and framing error must not advance the assembler.
    pulse_clr();
    send_frame(8'h77, 1'b1);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    send_frame(8'h99, 1'b0);
    repeat (2 * BAUD) @(negedge clk);
    check("glitch_no_rdy", cmd_rdy, 0);
    send_frame(8'h88, 1'b1);
    send_frame(8'h99, 1'b1);
    check("glitch_rdy", cmd_rdy, 1);
    check("glitch_cmd", cmd, 24'h778899);

    // Acknowledge on the very clock the third byte completes: set wins.
    pulse_clr();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    seen = 1'b0;
    fork
      send_frame(8'h03, 1'b1);
      begin
        for (int c = 0; c < 12 * BAUD && !seen; c++) begin
          @(negedge clk);
          if (dut.byte_rdy === 1'b1) begin
            clr_cmd_rdy = 1'b1;
            seen = 1'b1;
          end
        end
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    check("coincide_seen", seen, 1);
    check("coincide_rdy", cmd_rdy, 1);
    check("coincide_cmd", cmd, 24'h010203);
    // A following byte drops cmd_rdy and replaces only the first command byte.
    send_frame(8'h5A, 1'b1);
    check("next_byte_rdy", cmd_rdy, 0);
    check("next_byte_cmd", cmd, 24'h5A0203);

    // Reset in the middle of the second byte, with TX busy.
    pulse_clr();
    send_frame(8'h12, 1'b1);
    tx_data = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
    RX = 1'b0;
    repeat (BAUD / 2) @(negedge clk);
    check("pre_rst_tx_busy", TX, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_TX", TX, 1);
    check("mid_rst_tx_done", tx_done, 0);
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    check("mid_rst_cmd", cmd, 0);
    rst = 1'b0;
    RX = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    check("post_rst_tx_aborted", {TX, tx_done}, 2'b10);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check("post_rst_partial", cmd_rdy, 0);
    send_frame(8'h56, 1'b1);
    check("post_rst_rdy", cmd_rdy, 1);
    check("post_rst_cmd", cmd, 24'h123456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_comm.md
UART_COMM -- requirements
Module: uart_comm

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200 baud); legal range 16 or more.
REQ-002 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 Port rst, input, 1, reset; asynchronous and active-high.
REQ-004 Port clr_cmd_rdy, input, 1, consumer acknowledge: clears cmd_rdy and resynchronises the byte counter.
REQ-005 Port trmt, input, 1, one-clock-or-longer request to transmit tx_data.
REQ-006 Port tx_data, input, 8, byte to transmit; sampled on the clock where trmt is seen while idle.
REQ-007 Port RX, input, 1, serial receive line; idle high; asynchronous to clk.
REQ-008 Port cmd_rdy, output, 1, high when a complete 3-byte command is held in cmd.
REQ-009 Port cmd, output, 24, assembled command; first received byte in cmd[23:16], last in cmd[7:0].
REQ-010 Port tx_done, output, 1, high once a transmit frame has completed; held until the next accepted trmt.
REQ-011 Port TX, output, 1, serial transmit line; idle high.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1, each BAUD_DIV clocks.
REQ-013 RX SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Receiver SHALL detect start on a synchronised high-to-low transition while idle and sample each bit at BAUD_DIV/2 into the bit.
REQ-015 Receiver SHALL re-check the start bit at mid-bit and return to idle, with no byte, if it reads 1.
REQ-016 A byte SHALL complete at the stop-bit mid sample; stop bit 0 (framing error) SHALL discard the byte.
REQ-017 The command assembler SHALL have states WAIT_B1 -> WAIT_B2 -> WAIT_B3 -> WAIT_B1, advancing on each completed byte.
REQ-018 Assembler bytes SHALL load as follows: WAIT_B1 -> cmd[23:16], WAIT_B2 -> cmd[15:8], WAIT_B3 -> cmd[7:0].
REQ-019 cmd_rdy SHALL rise on the clock after the third byte completes; cmd SHALL equal the full 24-bit value on that clock.
REQ-020 cmd_rdy SHALL remain high until clr_cmd_rdy is high or the next byte completes, whichever comes first.
REQ-021 cmd bytes SHALL not change while cmd_rdy is high, except when a new first byte arrives (which also clears cmd_rdy).
REQ-022 While clr_cmd_rdy is high: cmd_rdy = 0 and state forced to WAIT_B1; bytes received during that time are still assembled normally.
REQ-023 If clr_cmd_rdy and a completing third byte coincide, set SHALL win and cmd_rdy SHALL rise.
REQ-024 Transmitter: trmt while idle SHALL load tx_data, clear tx_done and start the frame on the next clock.
REQ-025 trmt while the transmitter is busy SHALL be ignored.
REQ-026 tx_done SHALL rise on the clock the stop bit's BAUD_DIV period ends.
REQ-027 The receive and transmit paths SHALL be fully independent and full duplex.

Reset
REQ-028 rst SHALL asynchronously force the following: TX = 1, tx_done = 0, cmd_rdy = 0, cmd = 0, assembler WAIT_B1, RX and TX FSMs idle, counters 0, synchroniser flops 1.
REQ-029 rst asserted mid-frame SHALL abort the frame; after release, a partial command SHALL not be completed.

Structure
REQ-030 Package uart_pkg SHALL hold the BAUD_DIV default, the CMD_BYTES = 3 constant and the assembler state enum.
REQ-031 Serialisation SHALL live in one sub-module, uart, with ports clk, rst, tx_data, trmt, TX, tx_done, RX, rx_data, rdy, clr_rdy; uart_comm adds only the assembler.
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 With a bench UART as sender, send bytes 02, 1A, BC -> cmd_rdy rises once with cmd = 24'h021ABC.
REQ-034 Hold clr_cmd_rdy high, then release it and send 09, 36, CA -> cmd_rdy drops, then rises with cmd = 24'h0936CA.
REQ-035 Send two bytes, pulse clr_cmd_rdy, then send AA, BB, CC -> cmd = 24'hAABBCC; the stale bytes are discarded.
REQ-036 trmt with tx_data = 8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1, each BAUD_DIV clocks, then tx_done = 1; a second trmt during the frame is ignored.
REQ-037 Start-bit glitch shorter than BAUD_DIV/2, and a frame with stop bit 0 -> no byte is assembled and the state is unchanged.
REQ-038 rst pulse mid-second-byte, then send 12, 34, 56 -> cmd = 24'h123456 with all outputs at reset values during rst.
